// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the framebuffer serializer.
package fb_pkg;

  localparam int DRIVERS     = 30;
  localparam int CHANNELS    = 48;
  localparam int GS_BITS     = 9;
  localparam int STREAM_BITS = CHANNELS * GS_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_STREAM
  } fb_state_t;

endpackage

// File: rtl/fb_word_shifter.sv
// Double-buffered channel word: a shadow register catches the next RAM word
// while the shift register sends the current one out MSB first on every lane.
module fb_word_shifter #(
  parameter int DRIVERS = fb_pkg::DRIVERS,
  parameter int GS_BITS = fb_pkg::GS_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       capture,
  input  logic                       load,
  input  logic                       shift,
  input  logic [DRIVERS*GS_BITS-1:0] din,
  output logic [DRIVERS-1:0]         msb
);

  logic [DRIVERS*GS_BITS-1:0] shadow;
  logic [DRIVERS*GS_BITS-1:0] sreg;

  // NOTE: these are plain registers, not a RAM, so clearing them on reset is
  // cheap and keeps a mid-stream reset from leaving stale data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      sreg   <= '0;
    end else begin
      if (capture) shadow <= din;
      // A capture coinciding with a load bypasses the shadow (first word).
      if (load) begin
        sreg <= capture ? din : shadow;
      end else if (shift) begin
        for (int d = 0; d < DRIVERS; d++) begin
          sreg[d*GS_BITS +: GS_BITS] <= {sreg[d*GS_BITS +: GS_BITS-1], 1'b0};
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < DRIVERS; d++) begin
      msb[d] = sreg[d*GS_BITS + GS_BITS - 1];
    end
  end

endmodule

// File: rtl/framebuffer_serializer.sv
// Fetches one slice from framebuffer RAM and streams it as 432 gapless
// cycles of 30-lane serial data, channel 47 first, MSB first per channel.
module framebuffer_serializer
  import fb_pkg::*;
#(
  parameter int DRIVERS     = fb_pkg::DRIVERS,
  parameter int CHANNELS    = fb_pkg::CHANNELS,
  parameter int GS_BITS     = fb_pkg::GS_BITS,
  parameter int SLICE_COUNT = 256,
  parameter int RAM_LATENCY = 1,
  localparam int SW = $clog2(SLICE_COUNT),
  localparam int AW = $clog2(SLICE_COUNT*CHANNELS)
) (
  input  logic                       clk_33,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SW-1:0]              slice_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err_slice,
  output logic                       ram_rd,
  output logic [AW-1:0]              ram_addr,
  input  logic [DRIVERS*GS_BITS-1:0] ram_rdata,
  output logic [DRIVERS-1:0]         framebuffer_dat,
  output logic                       framebuffer_sync
);

  localparam int BCW = $clog2(GS_BITS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(GS_BITS - 1);
  localparam logic [BCW-1:0] BIT_LAND = BCW'(RAM_LATENCY);
  localparam logic [5:0]     CH_FIRST = 6'(CHANNELS - 1);

  fb_state_t          state, next_state;
  logic [SW-1:0]      slice_q;
  logic [5:0]         ch_cnt;
  logic [BCW-1:0]     bit_cnt;
  logic               done_q, err_q;
  logic               slice_ok;
  logic               rd, capture, load, shift;
  logic [5:0]         rd_ch;
  logic [DRIVERS-1:0] lane_msb;

  assign slice_ok = 32'(slice_idx) < SLICE_COUNT;

  // In PREFETCH the bit counter doubles as the RAM latency counter.
  always_ff @(posedge clk_33 or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      slice_q <= '0;
      ch_cnt  <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && slice_ok) begin
            slice_q <= slice_idx;
            ch_cnt  <= CH_FIRST;
            bit_cnt <= '0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        ST_PREFETCH: begin
          bit_cnt <= (bit_cnt == BIT_LAND) ? '0 : bit_cnt + 1'b1;
        end
        ST_STREAM: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (ch_cnt == '0) done_q <= 1'b1;
            else              ch_cnt <= ch_cnt - 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    rd         = 1'b0;
    rd_ch      = ch_cnt;
    capture    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && slice_ok) next_state = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        rd = (bit_cnt == '0);
        if (bit_cnt == BIT_LAND) begin
          capture    = 1'b1;
          load       = 1'b1;
          next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        shift = 1'b1;
        if (bit_cnt == '0 && ch_cnt != '0) begin
          rd    = 1'b1;
          rd_ch = ch_cnt - 1'b1;
        end
        if (bit_cnt == BIT_LAND && ch_cnt != '0) capture = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          if (ch_cnt != '0) begin
            load  = 1'b1;
            shift = 1'b0;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  fb_word_shifter #(
    .DRIVERS (DRIVERS),
    .GS_BITS (GS_BITS)
  ) u_shifter (
    .clk     (clk_33),
    .rst     (rst),
    .capture (capture),
    .load    (load),
    .shift   (shift),
    .din     (ram_rdata),
    .msb     (lane_msb)
  );

  assign ram_rd           = rd;
  assign ram_addr         = rd ? AW'(slice_q) * AW'(CHANNELS) + AW'(rd_ch) : '0;
  assign busy             = (state != ST_IDLE);
  assign done             = done_q;
  assign err_slice        = err_q;
  assign framebuffer_dat  = (state == ST_STREAM) ? lane_msb : '0;
  assign framebuffer_sync = (state == ST_STREAM) && (ch_cnt == CH_FIRST) && (bit_cnt == '0);

endmodule

// File: tb/tb_framebuffer_serializer.sv
// Directed scoreboard bench: four serializer instances (latency 1/4/8 and a
// 200-slice variant) share one clock; each has its own latency-accurate RAM model.
module tb_framebuffer_serializer;
  import fb_pkg::*;

  localparam int DW = DRIVERS * GS_BITS;
  localparam int SW = 8;
  localparam int AW = 14;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #15 clk = ~clk;

  logic               rst;
  logic               start      [N];
  logic [SW-1:0]      slice_idx  [N];
  logic               busy       [N];
  logic               done       [N];
  logic               err_slice  [N];
  logic               ram_rd     [N];
  logic [AW-1:0]      ram_addr   [N];
  logic [DW-1:0]      ram_rdata  [N];
  logic [DRIVERS-1:0] fb_dat     [N];
  logic               fb_sync    [N];

  int n_total = 0;
  int n_pass  = 0;

  logic [DRIVERS-1:0] bit_q [$];
  logic [AW-1:0]      addr_q[$];

  function automatic int lat_of(input int i);
    return (i == 1) ? 4 : (i == 2) ? 8 : 1;
  endfunction

  function automatic logic [8:0] gs_word(input int slice, input int ch, input int d);
    return 9'((ch * 7 + d + slice * 5) % 512);
  endfunction

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    int slice, ch;
    slice = int'(addr) / CHANNELS;
    ch    = int'(addr) % CHANNELS;
    for (int d = 0; d < DRIVERS; d++) w[d*GS_BITS +: GS_BITS] = gs_word(slice, ch, d);
    return w;
  endfunction

  framebuffer_serializer #(.SLICE_COUNT(256), .RAM_LATENCY(1)) u_l1 (
    .clk_33(clk), .rst(rst), .start(start[0]), .slice_idx(slice_idx[0]),
    .busy(busy[0]), .done(done[0]), .err_slice(err_slice[0]), .ram_rd(ram_rd[0]),
    .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0]), .framebuffer_dat(fb_dat[0]),
    .framebuffer_sync(fb_sync[0]));

  framebuffer_serializer #(.SLICE_COUNT(256), .RAM_LATENCY(4)) u_l4 (
    .clk_33(clk), .rst(rst), .start(start[1]), .slice_idx(slice_idx[1]),
    .busy(busy[1]), .done(done[1]), .err_slice(err_slice[1]), .ram_rd(ram_rd[1]),
    .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1]), .framebuffer_dat(fb_dat[1]),
    .framebuffer_sync(fb_sync[1]));

  framebuffer_serializer #(.SLICE_COUNT(256), .RAM_LATENCY(8)) u_l8 (
    .clk_33(clk), .rst(rst), .start(start[2]), .slice_idx(slice_idx[2]),
    .busy(busy[2]), .done(done[2]), .err_slice(err_slice[2]), .ram_rd(ram_rd[2]),
    .ram_addr(ram_addr[2]), .ram_rdata(ram_rdata[2]), .framebuffer_dat(fb_dat[2]),
    .framebuffer_sync(fb_sync[2]));

  framebuffer_serializer #(.SLICE_COUNT(200), .RAM_LATENCY(1)) u_sc (
    .clk_33(clk), .rst(rst), .start(start[3]), .slice_idx(slice_idx[3]),
    .busy(busy[3]), .done(done[3]), .err_slice(err_slice[3]), .ram_rd(ram_rd[3]),
    .ram_addr(ram_addr[3]), .ram_rdata(ram_rdata[3]), .framebuffer_dat(fb_dat[3]),
    .framebuffer_sync(fb_sync[3]));

  // RAM model: a read strobed in cycle R presents its word during cycle R+L.
  logic [AW-1:0] pa [N][8];
  logic          pv [N][8];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int k = 7; k > 0; k--) begin
        pa[i][k] <= pa[i][k-1];
        pv[i][k] <= pv[i][k-1];
      end
      pa[i][0] <= ram_addr[i];
      pv[i][0] <= ram_rd[i] && !rst;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ram_rdata[i] = {(DW/2){2'b10}};
      if (pv[i][lat_of(i)-1] === 1'b1) ram_rdata[i] = ram_word(pa[i][lat_of(i)-1]);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic push_slice(input int slice);
    logic [DRIVERS-1:0] v;
    logic [8:0] w;
    for (int ch = CHANNELS - 1; ch >= 0; ch--) begin
      addr_q.push_back(AW'(slice * CHANNELS + ch));
      for (int b = 0; b < GS_BITS; b++) begin
        for (int d = 0; d < DRIVERS; d++) begin
          w    = gs_word(slice, ch, d);
          v[d] = w[GS_BITS-1-b];
        end
        bit_q.push_back(v);
      end
    end
  endtask

  // Called at a falling edge: the start pulse is sampled on the next rising edge.
  task automatic begin_slice(input int inst, input int slice);
    start[inst]     = 1'b1;
    slice_idx[inst] = SW'(slice);
    push_slice(slice);
  endtask

  task automatic check_rd(input int inst, inout int rd_cnt);
    if (ram_rd[inst]) begin
      rd_cnt++;
      if (addr_q.size() == 0) check("extra_ram_rd", 64'd1, 64'd0);
      else                    check("ram_addr", 64'(ram_addr[inst]), 64'(addr_q.pop_front()));
    end
  endtask

  task automatic finish_slice(input int inst, input int start_at, input int rst_at,
                              input int chain_slice);
    int  k, rd_cnt, done_cnt, sync_cnt;
    bit  found;
    rd_cnt = 0; done_cnt = 0; sync_cnt = 0; found = 0;
    @(negedge clk);
    start[inst] = 1'b0;
    check("busy_t1", 64'(busy[inst]), 64'd1);
    check("ram_rd_t1", 64'(ram_rd[inst]), 64'd1);
    check_rd(inst, rd_cnt);
    k = 1;
    while (!found && k < 20) begin
      @(negedge clk);
      k++;
      if (fb_sync[inst]) found = 1;
      else check_rd(inst, rd_cnt);
    end
    check("sync_cycle", 64'(k), 64'(2 + lat_of(inst)));
    if (!found) begin
      bit_q.delete(); addr_q.delete();
      return;
    end
    for (int b = 0; b < STREAM_BITS; b++) begin
      if (b > 0) @(negedge clk);
      check("stream_dat", 64'(fb_dat[inst]), 64'(bit_q.pop_front()));
      sync_cnt += int'(fb_sync[inst]);
      done_cnt += int'(done[inst]);
      check_rd(inst, rd_cnt);
      if (b == start_at) begin
        start[inst]     = 1'b1;
        slice_idx[inst] = 8'd3;
      end
      if (b == start_at + 1) start[inst] = 1'b0;
      if (b == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_outputs", 64'({busy[inst], done[inst], err_slice[inst], ram_rd[inst],
                                  fb_sync[inst], fb_dat[inst], ram_addr[inst]}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bit_q.delete(); addr_q.delete();
        return;
      end
    end
    @(negedge clk);
    check("done_pulse", 64'(done[inst]), 64'd1);
    check("busy_fall", 64'(busy[inst]), 64'd0);
    check("dat_idle", 64'(fb_dat[inst]), 64'd0);
    check("sync_count", 64'(sync_cnt), 64'd1);
    check("early_done", 64'(done_cnt), 64'd0);
    check("rd_count", 64'(rd_cnt), 64'(CHANNELS));
    check("addr_q_empty", 64'(addr_q.size()), 64'd0);
    check("bit_q_empty", 64'(bit_q.size()), 64'd0);
    if (chain_slice >= 0) begin
      begin_slice(inst, chain_slice);
    end else begin
      @(negedge clk);
      check("done_single", 64'(done[inst]), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start[i]     = 1'b0;
      slice_idx[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_state", 64'({busy[i], done[i], err_slice[i], ram_rd[i], fb_sync[i],
                                fb_dat[i], ram_addr[i]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic slice and full-range address check.
    begin_slice(0, 0);   finish_slice(0, -1, -1, -1);
    begin_slice(0, 255); finish_slice(0, -1, -1, -1);

    // Out-of-range slice on the 200-slice variant, then its last legal slice.
    start[3] = 1'b1; slice_idx[3] = 8'd200;
    @(negedge clk);
    start[3] = 1'b0;
    check("err_pulse", 64'(err_slice[3]), 64'd1);
    check("err_no_rd", 64'(ram_rd[3]), 64'd0);
    check("err_busy", 64'(busy[3]), 64'd0);
    @(negedge clk);
    check("err_single", 64'(err_slice[3]), 64'd0);
    check("err_busy_after", 64'(busy[3]), 64'd0);
    check("err_no_rd_after", 64'(ram_rd[3]), 64'd0);
    begin_slice(3, 199); finish_slice(3, -1, -1, -1);

    // Start pulse in the middle of a stream is ignored.
    begin_slice(0, 2); finish_slice(0, 100, -1, -1);

    // Latency sweep: same expected data at every latency.
    begin_slice(1, 0); finish_slice(1, -1, -1, -1);
    begin_slice(2, 0); finish_slice(2, -1, -1, -1);

    // Reset mid-stream, then a clean restart.
    begin_slice(2, 4); finish_slice(2, -1, 200, -1);
    check("post_rst_idle", 64'(busy[2]), 64'd0);
    begin_slice(2, 5); finish_slice(2, -1, -1, -1);

    // Back-to-back slices, second start in the done cycle.
    begin_slice(0, 0); finish_slice(0, -1, -1, 1);
    finish_slice(0, -1, -1, -1);
    begin_slice(1, 6); finish_slice(1, -1, -1, 7);
    finish_slice(1, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
